// File: rtl/multibank_pkg.sv
// rtl/multibank_pkg.sv - shared types and default sizing for the multibank RAM write controller
package multibank_pkg;

  // Occupancy of one RAM bank
  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Controller: RUN writes samples, STALL discards them until the target bank frees up
  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_STALL = 1'b1
  } ctrl_state_t;

  localparam int DEF_DEPTH    = 35500;
  localparam int DEF_AW       = 16;
  localparam int DEF_PL_PULSE = 11;

endpackage

// File: rtl/bank_slot.sv
// rtl/bank_slot.sv - per-bank occupancy state, consumer release edge detector and pl_full pulse timer
module bank_slot
  import multibank_pkg::*;
#(
  parameter int PL_PULSE     = DEF_PL_PULSE,
  parameter bit INIT_FILLING = 1'b0
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        ps_done,
  input  logic        start_fill,
  input  logic        frame_end,
  output bank_state_t state,
  output logic        rel,
  output logic        pl_full,
  output logic        ps_full
);

  localparam logic [7:0] PULSE_LEN = 8'(PL_PULSE);

  logic       done_q1;
  logic       done_q2;
  logic [7:0] pulse_cnt;

  // Two-flop history of the consumer level; a 0->1 step is the release request
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      done_q1 <= 1'b0;
      done_q2 <= 1'b0;
    end else begin
      done_q1 <= ps_done;
      done_q2 <= done_q1;
    end
  end

  // Only a bank that is actually full can be handed back
  assign rel = done_q1 && !done_q2 && (state == BANK_FULL);

  // Occupancy: frame end fills, controller hand-off starts filling, release frees
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state <= INIT_FILLING ? BANK_FILLING : BANK_FREE;
    end else if (frame_end) begin
      state <= BANK_FULL;
    end else if (start_fill) begin
      state <= BANK_FILLING;
    end else if (rel) begin
      state <= BANK_FREE;
    end
  end

  // pl_full pulse timer; a fresh frame end reloads it even mid-pulse
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      pulse_cnt <= 8'd0;
    end else if (frame_end) begin
      pulse_cnt <= PULSE_LEN;
    end else if (pulse_cnt != 8'd0) begin
      pulse_cnt <= pulse_cnt - 8'd1;
    end
  end

  assign pl_full = (pulse_cnt != 8'd0);
  assign ps_full = (state == BANK_FULL);

endmodule

// File: rtl/multibank_ram_ctrl.sv
// rtl/multibank_ram_ctrl.sv - rotates FIR samples across NBANK RAM banks with full/release handshake
module multibank_ram_ctrl
  import multibank_pkg::*;
#(
  parameter int NBANK    = 2,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int PL_PULSE = DEF_PL_PULSE
) (
  input  logic                     clk_100m,
  input  logic                     rst_n,
  input  logic                     din_vld,
  input  logic                     din_last,
  input  logic [NBANK-1:0]         ps_done,
  input  logic                     ovf_clr,
  output logic [NBANK-1:0]         bank_we,
  output logic [AW-1:0]            addr_wr,
  output logic [$clog2(NBANK)-1:0] wr_bank,
  output logic [NBANK-1:0]         pl_full,
  output logic [NBANK-1:0]         ps_full,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int          BW        = $clog2(NBANK);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  ctrl_state_t       state_q;
  ctrl_state_t       state_d;
  logic [BW-1:0]     next_bank;
  logic              frame_end;
  logic              go_stall;
  logic [NBANK-1:0]  start_fill;
  logic [NBANK-1:0]  slot_end;
  logic [NBANK-1:0]  rel;
  bank_state_t       bank_st [NBANK];
  logic              drop_inc;
  logic [15:0]       drop_base;
  logic [15:0]       drop_next;

  assign next_bank = (wr_bank == BW'(NBANK - 1)) ? '0 : wr_bank + 1'b1;

  // Controller next state, write enables and bank hand-off strobes
  always_comb begin
    state_d    = state_q;
    bank_we    = '0;
    start_fill = '0;
    slot_end   = '0;
    frame_end  = 1'b0;
    go_stall   = 1'b0;
    case (state_q)
      CTRL_RUN: begin
        bank_we[wr_bank] = din_vld;
        if (din_vld && (din_last || addr_wr == LAST_ADDR)) begin
          frame_end         = 1'b1;
          slot_end[wr_bank] = 1'b1;
          // A release landing on this same edge counts as a free bank
          if (bank_st[next_bank] == BANK_FULL && !rel[next_bank]) begin
            state_d  = CTRL_STALL;
            go_stall = 1'b1;
          end else begin
            start_fill[next_bank] = 1'b1;
          end
        end
      end
      CTRL_STALL: begin
        if (rel[wr_bank]) begin
          state_d             = CTRL_RUN;
          start_fill[wr_bank] = 1'b1;
        end
      end
      default: state_d = CTRL_RUN;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state_q <= CTRL_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Write pointer: address advances per accepted sample, bank advances per frame
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      wr_bank <= '0;
      addr_wr <= '0;
    end else if (frame_end) begin
      wr_bank <= next_bank;
      addr_wr <= '0;
    end else if (state_q == CTRL_RUN && din_vld) begin
      addr_wr <= addr_wr + 1'b1;
    end
  end

  assign drop_inc  = (state_q == CTRL_STALL) && din_vld;
  assign drop_base = ovf_clr ? 16'd0 : drop_cnt;
  assign drop_next = (drop_inc && drop_base != 16'hFFFF) ? drop_base + 16'd1 : drop_base;

  // Sticky overflow flag and saturating discard counter; a new stall beats a clear
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else begin
      if (go_stall) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      drop_cnt <= drop_next;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    bank_slot #(
      .PL_PULSE    (PL_PULSE),
      .INIT_FILLING(b == 0)
    ) u_slot (
      .clk_100m  (clk_100m),
      .rst_n     (rst_n),
      .ps_done   (ps_done[b]),
      .start_fill(start_fill[b]),
      .frame_end (slot_end[b]),
      .state     (bank_st[b]),
      .rel       (rel[b]),
      .pl_full   (pl_full[b]),
      .ps_full   (ps_full[b])
    );
  end

endmodule

// File: tb/tb_multibank_ram_ctrl.sv
// tb/tb_multibank_ram_ctrl.sv - directed scoreboard bench for the multibank RAM write controller
module tb_multibank_ram_ctrl;

  logic        clk_100m = 1'b0;
  logic        rst_n    = 1'b0;
  logic        ovf_clr  = 1'b0;

  logic        vld2 = 1'b0;
  logic        last2 = 1'b0;
  logic [1:0]  psd2 = 2'b00;
  logic [1:0]  we2;
  logic [15:0] addr2;
  logic [0:0]  wrb2;
  logic [1:0]  plf2;
  logic [1:0]  psf2;
  logic        ovf2;
  logic [15:0] drop2;

  logic        vld4 = 1'b0;
  logic        last4 = 1'b0;
  logic [3:0]  psd4 = 4'b0000;
  logic [3:0]  we4;
  logic [15:0] addr4;
  logic [1:0]  wrb4;
  logic [3:0]  plf4;
  logic [3:0]  psf4;
  logic        ovf4;
  logic [15:0] drop4;

  multibank_ram_ctrl #(.NBANK(2), .DEPTH(8)) u_dut2 (
    .clk_100m(clk_100m), .rst_n(rst_n), .din_vld(vld2), .din_last(last2),
    .ps_done(psd2), .ovf_clr(ovf_clr), .bank_we(we2), .addr_wr(addr2),
    .wr_bank(wrb2), .pl_full(plf2), .ps_full(psf2), .overflow(ovf2), .drop_cnt(drop2)
  );

  multibank_ram_ctrl #(.NBANK(4), .DEPTH(8)) u_dut4 (
    .clk_100m(clk_100m), .rst_n(rst_n), .din_vld(vld4), .din_last(last4),
    .ps_done(psd4), .ovf_clr(ovf_clr), .bank_we(we4), .addr_wr(addr4),
    .wr_bank(wrb4), .pl_full(plf4), .ps_full(psf4), .overflow(ovf4), .drop_cnt(drop4)
  );

  always #5 clk_100m = ~clk_100m;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  we;
    logic [15:0] addr;
  } wr_t;

  wr_t q2[$];
  wr_t q4[$];
  wr_t e2;
  wr_t e4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input int bank, input int addr);
    wr_t r;
    r.we   = 4'b0001 << bank;
    r.addr = 16'(addr);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic send2(input logic last);
    vld2 = 1'b1;
    last2 = last;
    tick();
    vld2 = 1'b0;
    last2 = 1'b0;
  endtask

  task automatic send4(input logic last);
    vld4 = 1'b1;
    last4 = last;
    tick();
    vld4 = 1'b0;
    last4 = 1'b0;
  endtask

  // Every RAM write seen on the 2-bank DUT must match the next expected write
  always @(negedge clk_100m) begin
    if (rst_n && we2 != 2'b00) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_write", 32'(we2), 32'd0);
      end else begin
        e2 = q2.pop_front();
        check("dut2_bank_we", 32'(we2), 32'(e2.we));
        check("dut2_addr_wr", 32'(addr2), 32'(e2.addr));
      end
    end
  end

  // Every RAM write seen on the 4-bank DUT must match the next expected write
  always @(negedge clk_100m) begin
    if (rst_n && we4 != 4'b0000) begin
      if (q4.size() == 0) begin
        check("dut4_unexpected_write", 32'(we4), 32'd0);
      end else begin
        e4 = q4.pop_front();
        check("dut4_bank_we", 32'(we4), 32'(e4.we));
        check("dut4_addr_wr", 32'(addr4), 32'(e4.addr));
      end
    end
  end

  initial begin
    int n;

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_wr_bank", 32'(wrb2), 32'd0);
    check("rst_addr_wr", 32'(addr2), 32'd0);
    check("rst_pl_full", 32'(plf2), 32'd0);
    check("rst_ps_full", 32'(psf2), 32'd0);
    check("rst_overflow", 32'(ovf2), 32'd0);
    check("rst_drop_cnt", 32'(drop2), 32'd0);
    check("rst_bank_we", 32'(we2), 32'd0);
    check("rst4_wr_bank", 32'(wrb4), 32'd0);

    // Explicit last on the 8th sample
    for (int a = 0; a < 8; a++) begin
      q2.push_back(mk(0, a));
      send2(a == 7);
    end
    check("f1_ps_full", 32'(psf2), 32'h1);
    check("f1_pl_full", 32'(plf2), 32'h1);
    check("f1_wr_bank", 32'(wrb2), 32'd1);
    check("f1_addr_wr", 32'(addr2), 32'd0);
    check("f1_overflow", 32'(ovf2), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (plf2[0]) n++;
      tick();
    end
    check("f1_pl_pulse_len", 32'(n), 32'd11);

    // Auto-last at DEPTH-1; bank 0 is still full so the controller stalls
    for (int a = 0; a < 8; a++) begin
      q2.push_back(mk(1, a));
      send2(1'b0);
    end
    check("f2_ps_full", 32'(psf2), 32'h3);
    check("f2_pl_full", 32'(plf2), 32'h2);
    check("f2_wr_bank", 32'(wrb2), 32'd0);
    check("f2_addr_wr", 32'(addr2), 32'd0);
    check("f2_overflow", 32'(ovf2), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (plf2[1]) n++;
      tick();
    end
    check("f2_pl_pulse_len", 32'(n), 32'd11);

    // Third frame arrives while stalled: all five samples dropped
    for (int i = 0; i < 5; i++) begin
      vld2 = 1'b1;
      #1;
      check("stall_bank_we", 32'(we2), 32'd0);
      tick();
    end
    vld2 = 1'b0;
    check("stall_drop_cnt", 32'(drop2), 32'd5);
    check("stall_overflow", 32'(ovf2), 32'd1);
    check("stall_addr_wr", 32'(addr2), 32'd0);

    // Release bank 0: ps_full falls on the second edge
    psd2 = 2'b01;
    tick();
    check("rel_edge1_ps_full", 32'(psf2), 32'h3);
    tick();
    check("rel_edge2_ps_full", 32'(psf2), 32'h2);
    check("rel_wr_bank", 32'(wrb2), 32'd0);
    check("rel_overflow_sticky", 32'(ovf2), 32'd1);
    q2.push_back(mk(0, 0));
    send2(1'b0);
    check("resume_addr_wr", 32'(addr2), 32'd1);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_overflow", 32'(ovf2), 32'd0);
    check("clr_drop_cnt", 32'(drop2), 32'd0);

    // A release edge on a bank that is filling must change nothing
    psd2 = 2'b00;
    tick();
    psd2 = 2'b01;
    tick();
    tick();
    q2.push_back(mk(0, 1));
    send2(1'b0);
    check("ignore_rel_addr_wr", 32'(addr2), 32'd2);
    check("ignore_rel_wr_bank", 32'(wrb2), 32'd0);

    for (int a = 2; a < 8; a++) begin
      q2.push_back(mk(0, a));
      send2(1'b0);
    end
    check("f3_overflow", 32'(ovf2), 32'd1);
    check("f3_wr_bank", 32'(wrb2), 32'd1);
    check("f3_ps_full", 32'(psf2), 32'h3);

    psd2 = 2'b11;
    tick();
    tick();
    check("rel1_ps_full", 32'(psf2), 32'h1);
    for (int a = 0; a < 5; a++) begin
      q2.push_back(mk(1, a));
      send2(1'b0);
    end
    check("mid_addr_wr", 32'(addr2), 32'd5);
    check("mid_wr_bank", 32'(wrb2), 32'd1);

    // Reset in the middle of a frame on bank 1
    rst_n = 1'b0;
    psd2  = 2'b00;
    tick();
    rst_n = 1'b1;
    check("mrst_wr_bank", 32'(wrb2), 32'd0);
    check("mrst_addr_wr", 32'(addr2), 32'd0);
    check("mrst_pl_full", 32'(plf2), 32'd0);
    check("mrst_ps_full", 32'(psf2), 32'd0);
    check("mrst_overflow", 32'(ovf2), 32'd0);
    check("mrst_drop_cnt", 32'(drop2), 32'd0);
    q2.push_back(mk(0, 0));
    send2(1'b0);
    repeat (3) tick();
    check("post_rst_addr_wr", 32'(addr2), 32'd1);
    check("post_rst_pl_full", 32'(plf2), 32'd0);
    check("post_rst_ps_full", 32'(psf2), 32'd0);

    // Four banks: frames on 0,1,2, then free bank 0
    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < 2; a++) begin
        q4.push_back(mk(f, a));
        send4(a == 1);
      end
    end
    check("b4_ps_full", 32'(psf4), 32'h7);
    check("b4_wr_bank", 32'(wrb4), 32'd3);
    psd4 = 4'b0001;
    tick();
    tick();
    check("b4_rel0_ps_full", 32'(psf4), 32'h6);
    q4.push_back(mk(3, 0));
    send4(1'b0);
    q4.push_back(mk(3, 1));
    send4(1'b1);
    check("b4_f4_wr_bank", 32'(wrb4), 32'd0);
    check("b4_f4_overflow", 32'(ovf4), 32'd0);

    // Frame end on bank 0 coincides with release of full bank 1
    psd4 = 4'b0011;
    q4.push_back(mk(0, 0));
    send4(1'b0);
    q4.push_back(mk(0, 1));
    send4(1'b1);
    check("b4_race_wr_bank", 32'(wrb4), 32'd1);
    check("b4_race_overflow", 32'(ovf4), 32'd0);
    check("b4_race_ps_full", 32'(psf4), 32'hD);
    q4.push_back(mk(1, 0));
    send4(1'b0);
    check("b4_race_addr_wr", 32'(addr4), 32'd1);

    tick();
    check("q2_drained", 32'(q2.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multibank_ram_ctrl.md
MULTIBANK_RAM_CTRL -- requirements
Module: multibank_ram_ctrl

Interface
REQ-001 Parameter NBANK, default 2, number of RAM banks written in rotation (legal 2..8).
REQ-002 Parameter DEPTH, default 35500, samples per bank (legal 2..2^AW).
REQ-003 Parameter AW, default 16, write-address width.
REQ-004 Parameter PL_PULSE, default 11, pl_full pulse length in cycles (legal 1..255).
REQ-005 clk_100m  in  1  sole clock, 100 MHz.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 din_vld  in  1  one FIR output sample valid this cycle.
REQ-008 din_last  in  1  frame end; qualified only with din_vld, marks the final sample of a frame.
REQ-009 ps_done  in  NBANK  per-bank consumer level; its rising edge releases that bank.
REQ-010 ovf_clr  in  1  clears overflow and drop_cnt.
REQ-011 bank_we  out  NBANK  one-hot RAM write enable (also drives RAM en).
REQ-012 addr_wr  out  AW  write address shared by all banks.
REQ-013 wr_bank  out  clog2(NBANK)  index of bank currently being filled.
REQ-014 pl_full  out  NBANK  per-bank PL-side full pulse.
REQ-015 ps_full  out  NBANK  per-bank full level, held until consumer release.
REQ-016 overflow  out  1  sticky: a frame arrived with no free bank.
REQ-017 drop_cnt  out  16  saturating count of discarded samples.

Function
REQ-018 Each bank SHALL hold state FREE, FILLING or FULL; exactly one bank is FILLING while controller is in RUN.
REQ-019 Controller FSM SHALL have states RUN and STALL.
REQ-020 In RUN, bank_we[wr_bank] SHALL equal din_vld (combinational); all other bits 0; in STALL bank_we SHALL be 0.
REQ-021 The sample accepted at a cycle SHALL be written at the current registered addr_wr; addr_wr increments by 1 at the next edge.
REQ-022 Frame end SHALL occur on din_vld&&din_last, or on din_vld with addr_wr==DEPTH-1 (auto-last); the frame end SHALL reset addr_wr to 0 at the next edge.
REQ-023 At frame end, bank wr_bank -> FULL, ps_full[wr_bank] rises next cycle, pl_full[wr_bank] high for exactly PL_PULSE cycles starting next cycle.
REQ-024 At frame end, wr_bank SHALL advance to (wr_bank+1) mod NBANK; if that bank is FREE it becomes FILLING and FSM stays RUN.
REQ-025 If the next bank is FULL, FSM -> STALL, overflow set, wr_bank still advances.
REQ-026 In STALL, every din_vld SHALL increment drop_cnt (saturate at 65535); addr_wr held at 0.
REQ-027 STALL -> RUN at the edge where bank wr_bank is released; that bank becomes FILLING, first sample written at address 0.
REQ-028 ps_done SHALL pass a 2-flop edge detector; ps_full[b] clears, bank b -> FREE, on the second edge after ps_done[b] is first sampled high.
REQ-029 Release of a bank not FULL SHALL be ignored.
REQ-030 Release of bank k in the same cycle as a frame end advancing to k SHALL take priority: no overflow, k becomes FILLING.
REQ-031 New frame end on a bank whose pl_full pulse is running SHALL restart that bank's pulse count.
REQ-032 ovf_clr SHALL clear overflow and drop_cnt next edge; a simultaneous overflow event wins (overflow=1, drop_cnt=0 or 1).

Reset
REQ-033 While rst_n=0 at an edge: bank 0 FILLING, others FREE, FSM RUN, wr_bank=0, addr_wr=0, pl_full=0, ps_full=0, overflow=0, drop_cnt=0, edge-detector flops 0.
REQ-034 Reset mid-frame SHALL discard all bank and frame state; no pl_full pulse is produced for the aborted frame.

Structure
REQ-035 Shared package multibank_pkg SHALL hold the bank-state and FSM-state typedefs and default DEPTH/AW/PL_PULSE constants.
REQ-036 Per-bank logic (state, edge detector, pl_full pulse counter) SHALL be one sub-module, bank_slot, instantiated NBANK times.

Verification
REQ-037 NBANK=2, DEPTH=8: 8 vld samples, last on 8th -> addresses 0..7 on bank_we[0], pl_full[0] 11 cycles, ps_full[0]=1, wr_bank=1.
REQ-038 DEPTH=8, no din_last: 8 vld samples -> auto-last at addr 7, identical response to REQ-037.
REQ-039 NBANK=2: two frames, no ps_done, third frame of 5 samples -> overflow=1, bank_we=0, drop_cnt=5.
REQ-040 From REQ-039 state, raise ps_done[0] -> ps_full[0] falls 2 edges later, RUN resumes, next sample at bank 0 addr 0.
REQ-041 NBANK=4: ps_done[1] edge on same cycle as frame end advancing to bank 1 (previously FULL) -> no overflow, bank 1 FILLING.
REQ-042 rst_n=0 at addr 5 of bank 1 -> all outputs at REQ-033 values, next frame writes bank 0 from addr 0.
